// File: rtl/router_reg_pkt_if.sv
// router_reg_pkt_if: FSM strobes / input-port word on one side, FIFO write bus and status flags on the other.
// Define ROUTER_ERR_COUNT_EN to carry the err_count status bus.
interface router_reg_pkt_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  pkt_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  fifo_full;
    logic                  detect_add;
    logic                  lfd_state;
    logic                  ld_state;
    logic                  laf_state;
    logic                  full_state;
    logic                  rst_int_reg;

    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  skid_empty;
    logic                  skid_ovf;
    logic                  parity_done;
    logic                  low_packet_valid;
    logic                  err;

`ifdef ROUTER_ERR_COUNT_EN
    logic [7:0]            err_count;

    modport master (
        output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
               laf_state, full_state, rst_int_reg,
        input  dout, dout_valid, skid_empty, skid_ovf, parity_done,
               low_packet_valid, err, err_count
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
               laf_state, full_state, rst_int_reg,
        output dout, dout_valid, skid_empty, skid_ovf, parity_done,
               low_packet_valid, err, err_count
    );
`else
    modport master (
        output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
               laf_state, full_state, rst_int_reg,
        input  dout, dout_valid, skid_empty, skid_ovf, parity_done,
               low_packet_valid, err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
               laf_state, full_state, rst_int_reg,
        output dout, dout_valid, skid_empty, skid_ovf, parity_done,
               low_packet_valid, err
    );
`endif
endinterface

// File: rtl/router_reg_pkt.sv
// router_reg_pkt: router datapath register stage -- header capture, FIFO write data, overflow skid buffer, packet parity check.
// Optional: define ROUTER_ERR_COUNT_EN for a saturating parity-error counter on err_count.
module router_reg_pkt #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned SKID_DEPTH = 2
) (
    input  logic            clock,
    input  logic            resetn,
    router_reg_pkt_if.slave bus
);

    localparam int unsigned ADDR_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned PTR_W     = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(SKID_DEPTH + 1);

    logic [DATA_WIDTH-1:0] header_q,   header_d;
    logic [DATA_WIDTH-1:0] int_par_q,  int_par_d;
    logic [DATA_WIDTH-1:0] pkt_par_q,  pkt_par_d;
    logic [DATA_WIDTH-1:0] dout_q,     dout_d;
    logic                  dout_vld_q, dout_vld_d;
    logic                  empty_q,    empty_d;
    logic                  ovf_q,      ovf_d;
    logic                  pdone_q,    pdone_d;
    logic                  chk_q,      chk_d;
    logic                  lpv_q,      lpv_d;
    logic                  err_q,      err_d;
    logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;

    logic [DATA_WIDTH-1:0] skid_mem_q [SKID_DEPTH];

    logic addr_ok_c, hdr_c, accept_c, bypass_c, pop_c, push_req_c, push_c, drop_c;
    logic skid_full_c, par_word_c;

    // full_state has no datapath action: accepted words accumulate parity regardless of it
    logic unused_full_state_c;
    assign unused_full_state_c = bus.full_state;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        addr_ok_c   = 32'(bus.data_in[ADDR_BITS-1:0]) < NUM_PORTS;
        hdr_c       = bus.detect_add & bus.pkt_valid & addr_ok_c;
        accept_c    = bus.ld_state & bus.pkt_valid;
        par_word_c  = bus.ld_state & ~bus.pkt_valid;
        bypass_c    = accept_c & ~bus.fifo_full & empty_q;
        pop_c       = bus.laf_state & ~bus.fifo_full & ~empty_q;
        push_req_c  = accept_c & ~bypass_c;
        skid_full_c = (cnt_q == CNT_W'(SKID_DEPTH));
        // a same-cycle pop frees the slot the push needs
        push_c      = push_req_c & (~skid_full_c | pop_c);
        drop_c      = push_req_c & ~push_c;
    end

    // next-state for the whole stage; a valid header overrides every clear it implies
    always_comb begin
        header_d   = header_q;
        int_par_d  = int_par_q;
        pkt_par_d  = pkt_par_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        ovf_d      = ovf_q;
        pdone_d    = pdone_q;
        lpv_d      = lpv_q;
        err_d      = err_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;

        if (bus.lfd_state) begin
            dout_d     = header_q;
            dout_vld_d = 1'b1;
            int_par_d  = int_par_d ^ header_q;
        end
        if (accept_c) begin
            int_par_d = int_par_d ^ bus.data_in;
        end
        if (bypass_c) begin
            dout_d     = bus.data_in;
            dout_vld_d = 1'b1;
        end
        if (pop_c) begin
            dout_d     = skid_mem_q[rd_ptr_q];
            dout_vld_d = 1'b1;
            rd_ptr_d   = ptr_inc(rd_ptr_q);
        end
        if (push_c) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (push_c && !pop_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (drop_c) begin
            ovf_d = 1'b1;
        end
        if (par_word_c) begin
            pkt_par_d = bus.data_in;
        end
        if (bus.rst_int_reg) begin
            lpv_d = 1'b0;
        end else if (par_word_c) begin
            lpv_d = 1'b1;
        end
        if (lpv_q && empty_q && !pdone_q) begin
            pdone_d = 1'b1;
        end
        if (chk_q && (pkt_par_q != int_par_q)) begin
            err_d = 1'b1;
        end
        if (hdr_c) begin
            header_d  = bus.data_in;
            int_par_d = '0;
            pkt_par_d = '0;
            pdone_d   = 1'b0;
            err_d     = 1'b0;
            ovf_d     = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cnt_d     = '0;
        end

        // compare exactly once, on the cycle parity_done is first seen high
        chk_d   = pdone_d & ~pdone_q;
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_q   <= '0;
            int_par_q  <= '0;
            pkt_par_q  <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            pdone_q    <= 1'b0;
            chk_q      <= 1'b0;
            lpv_q      <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            header_q   <= header_d;
            int_par_q  <= int_par_d;
            pkt_par_q  <= pkt_par_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            pdone_q    <= pdone_d;
            chk_q      <= chk_d;
            lpv_q      <= lpv_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // skid storage is qualified by the pointers/count, so it needs no reset
    always_ff @(posedge clock) begin
        if (push_c) begin
            skid_mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.dout             = dout_q;
    assign bus.dout_valid       = dout_vld_q;
    assign bus.skid_empty       = empty_q;
    assign bus.skid_ovf         = ovf_q;
    assign bus.parity_done      = pdone_q;
    assign bus.low_packet_valid = lpv_q;
    assign bus.err              = err_q;

`ifdef ROUTER_ERR_COUNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // counts err rising edges, saturating; only reset clears it
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && !err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_router_reg_pkt.sv
// tb_router_reg_pkt: randomized and directed packets through router_reg_pkt, checked against a packet-level model.
// Build with ROUTER_ERR_COUNT_EN defined to also exercise err_count.
module tb_router_reg_pkt;

    localparam int unsigned DW = 8;
    localparam int unsigned NP = 3;
    localparam int unsigned SD = 2;

    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    router_reg_pkt_if #(.DATA_WIDTH(DW)) bus ();

    router_reg_pkt #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .SKID_DEPTH(SD)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] pay_q [$];
    bit         full_q [$];
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    bit         exp_ovf, exp_err;
    logic       o_pd, o_err, o_ovf, o_emp, o_lpv;

    // record every FIFO write the DUT issues
    always @(negedge clock) begin
        if (resetn === 1'b1 && bus.dout_valid === 1'b1) got_q.push_back(bus.dout);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pkt_valid   = 1'b0;
        bus.data_in     = '0;
        bus.fifo_full   = 1'b0;
        bus.detect_add  = 1'b0;
        bus.lfd_state   = 1'b0;
        bus.ld_state    = 1'b0;
        bus.laf_state   = 1'b0;
        bus.full_state  = 1'b0;
        bus.rst_int_reg = 1'b0;
    endtask

    // Packet-level model: once a word is blocked, the rest queue behind it until the buffer holds SD words.
    task automatic model_pkt(input logic [7:0] hdr, input logic [7:0] par);
        logic [7:0] x;
        int         held;
        bit         blocked;
        exp_q.delete();
        exp_q.push_back(hdr);
        x = hdr; held = 0; blocked = 0; exp_ovf = 0;
        foreach (pay_q[i]) begin
            x = x ^ pay_q[i];
            if (!full_q[i] && !blocked) exp_q.push_back(pay_q[i]);
            else begin
                blocked = 1;
                if (held < int'(SD)) begin held++; exp_q.push_back(pay_q[i]); end
                else exp_ovf = 1;
            end
        end
        exp_err = (x != par);
    endtask

    function automatic logic [7:0] good_par(input logic [7:0] hdr);
        logic [7:0] x = hdr;
        foreach (pay_q[i]) x = x ^ pay_q[i];
        return x;
    endfunction

    task automatic drive_pkt(input logic [7:0] hdr, input logic [7:0] par);
        int n;
        got_q.delete();
        bus.detect_add = 1'b1; bus.pkt_valid = 1'b1; bus.data_in = hdr;
        tick();
        bus.detect_add = 1'b0;
        bus.lfd_state = 1'b1;
        tick();
        bus.lfd_state = 1'b0;
        bus.ld_state  = 1'b1;
        foreach (pay_q[i]) begin
            bus.pkt_valid = 1'b1; bus.data_in = pay_q[i]; bus.fifo_full = full_q[i];
            bus.full_state = full_q[i];
            tick();
        end
        bus.pkt_valid = 1'b0; bus.data_in = par; bus.fifo_full = 1'b0; bus.full_state = 1'b0;
        tick();
        bus.ld_state = 1'b0;
        o_lpv = bus.low_packet_valid;
        bus.laf_state = 1'b1;
        n = 0;
        while (bus.skid_empty !== 1'b1 && n < 16) begin tick(); n++; end
        bus.laf_state = 1'b0;
        n = 0;
        while (bus.parity_done !== 1'b1 && n < 16) begin tick(); n++; end
        o_pd  = bus.parity_done;
        o_ovf = bus.skid_ovf;
        o_emp = bus.skid_empty;
        tick();
        o_err = bus.err;
        bus.rst_int_reg = 1'b1;
        tick();
        bus.rst_int_reg = 1'b0;
    endtask

    task automatic set_pkt(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input int len, input bit full_all);
        logic [7:0] w [3];
        w[0] = w0; w[1] = w1; w[2] = w2;
        pay_q.delete(); full_q.delete();
        for (int i = 0; i < len; i++) begin pay_q.push_back(w[i]); full_q.push_back(full_all); end
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        #12;
        n_tests++; if (bus.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %0h want 0", bus.dout); end
        n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %0b want 0", bus.dout_valid); end
        n_tests++; if (bus.skid_empty !== 1'b1) begin n_fail++; $display("FAIL reset_skid_empty: got %0b want 1", bus.skid_empty); end
        n_tests++; if (bus.skid_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_skid_ovf: got %0b want 0", bus.skid_ovf); end
        n_tests++; if (bus.parity_done !== 1'b0) begin n_fail++; $display("FAIL reset_parity_done: got %0b want 0", bus.parity_done); end
        n_tests++; if (bus.low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL reset_lpv: got %0b want 0", bus.low_packet_valid); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", bus.err); end
        @(negedge clock);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_good_packet();
        set_pkt(8'h11, 8'h22, 8'h00, 2, 1'b0);
        model_pkt(8'h05, 8'h36);
        drive_pkt(8'h05, 8'h36);
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL good_dout_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL good_dout[%0d]: got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
        end
        n_tests++; if (o_lpv !== 1'b1) begin n_fail++; $display("FAIL good_lpv: got %0b want 1", o_lpv); end
        n_tests++; if (o_pd !== 1'b1) begin n_fail++; $display("FAIL good_parity_done: got %0b want 1", o_pd); end
        n_tests++; if (o_err !== exp_err) begin n_fail++; $display("FAIL good_err: got %0b want %0b", o_err, exp_err); end
        n_tests++; if (bus.low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL good_lpv_clear: got %0b want 0", bus.low_packet_valid); end
    endtask

    task automatic test_bad_parity();
        set_pkt(8'h11, 8'h22, 8'h00, 2, 1'b0);
        model_pkt(8'h05, 8'h00);
        drive_pkt(8'h05, 8'h00);
        n_tests++; if (o_pd !== 1'b1) begin n_fail++; $display("FAIL bad_parity_done: got %0b want 1", o_pd); end
        n_tests++; if (o_err !== exp_err) begin n_fail++; $display("FAIL bad_err: got %0b want %0b", o_err, exp_err); end
        tick(); tick();
        n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL bad_err_held: got %0b want 1", bus.err); end
    endtask

    task automatic test_invalid_addr();
        bus.detect_add = 1'b1; bus.pkt_valid = 1'b1; bus.data_in = 8'h03;
        tick();
        bus.detect_add = 1'b0;
        n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL badaddr_err_kept: got %0b want 1", bus.err); end
        n_tests++; if (bus.parity_done !== 1'b1) begin n_fail++; $display("FAIL badaddr_pd_kept: got %0b want 1", bus.parity_done); end
        bus.lfd_state = 1'b1;
        tick();
        bus.lfd_state = 1'b0;
        n_tests++; if (bus.dout !== 8'h05 || bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL badaddr_header_kept: got %0h/%0b want 05/1", bus.dout, bus.dout_valid); end
        bus.detect_add = 1'b1; bus.pkt_valid = 1'b1; bus.data_in = 8'h09;
        tick();
        bus.detect_add = 1'b0; bus.pkt_valid = 1'b0;
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL newhdr_err_clear: got %0b want 0", bus.err); end
        n_tests++; if (bus.parity_done !== 1'b0) begin n_fail++; $display("FAIL newhdr_pd_clear: got %0b want 0", bus.parity_done); end
        bus.lfd_state = 1'b1;
        tick();
        bus.lfd_state = 1'b0;
        n_tests++; if (bus.dout !== 8'h09) begin n_fail++; $display("FAIL newhdr_dout: got %0h want 09", bus.dout); end
        tick();
        n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL idle_dout_valid: got %0b want 0", bus.dout_valid); end
    endtask

    task automatic test_backpressure();
        set_pkt(8'hA1, 8'hA2, 8'h00, 2, 1'b1);
        model_pkt(8'h05, good_par(8'h05));
        drive_pkt(8'h05, good_par(8'h05));
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_dout_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_dout[%0d]: got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
        end
        n_tests++; if (o_emp !== 1'b1) begin n_fail++; $display("FAIL bp_skid_empty: got %0b want 1", o_emp); end
        n_tests++; if (o_ovf !== exp_ovf) begin n_fail++; $display("FAIL bp_skid_ovf: got %0b want %0b", o_ovf, exp_ovf); end
        n_tests++; if (o_err !== exp_err) begin n_fail++; $display("FAIL bp_err: got %0b want %0b", o_err, exp_err); end
    endtask

    task automatic test_overflow();
        set_pkt(8'h01, 8'h02, 8'h03, 3, 1'b1);
        model_pkt(8'h05, 8'h05);
        drive_pkt(8'h05, 8'h05);
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_dout_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_dout[%0d]: got %0h want %0h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
        end
        n_tests++; if (o_ovf !== exp_ovf) begin n_fail++; $display("FAIL ovf_flag: got %0b want %0b", o_ovf, exp_ovf); end
        n_tests++; if (o_pd !== 1'b1) begin n_fail++; $display("FAIL ovf_parity_done: got %0b want 1", o_pd); end
        n_tests++; if (o_err !== exp_err) begin n_fail++; $display("FAIL ovf_err: got %0b want %0b", o_err, exp_err); end
    endtask

    task automatic test_random();
        logic [7:0] hdr, par;
        int         len;
        for (int p = 0; p < 30; p++) begin
            hdr = {6'($urandom_range(0, 63)), 2'($urandom_range(0, 2))};
            len = $urandom_range(1, 5);
            pay_q.delete(); full_q.delete();
            for (int i = 0; i < len; i++) begin
                pay_q.push_back(8'($urandom));
                full_q.push_back($urandom_range(0, 9) < 4);
            end
            par = good_par(hdr);
            if ($urandom_range(0, 2) == 0) par = par ^ 8'($urandom_range(1, 255));
            model_pkt(hdr, par);
            drive_pkt(hdr, par);
            n_tests++;
            if (got_q != exp_q) begin n_fail++; $display("FAIL rand%0d_dout: got %p want %p", p, got_q, exp_q); end
            n_tests++;
            if (o_ovf !== exp_ovf || o_err !== exp_err || o_pd !== 1'b1 || o_emp !== 1'b1) begin
                n_fail++;
                $display("FAIL rand%0d_flags: got ovf=%0b err=%0b pd=%0b empty=%0b want ovf=%0b err=%0b pd=1 empty=1",
                         p, o_ovf, o_err, o_pd, o_emp, exp_ovf, exp_err);
            end
        end
    endtask

    task automatic test_async_reset();
        bus.detect_add = 1'b1; bus.pkt_valid = 1'b1; bus.data_in = 8'h05;
        tick();
        bus.detect_add = 1'b0; bus.lfd_state = 1'b1;
        tick();
        bus.lfd_state = 1'b0; bus.ld_state = 1'b1; bus.fifo_full = 1'b1; bus.data_in = 8'h5A;
        tick();
        bus.data_in = 8'h5B;
        tick();
        n_tests++; if (bus.skid_empty !== 1'b0) begin n_fail++; $display("FAIL arst_pre_skid: got %0b want 0", bus.skid_empty); end
        #3 resetn = 1'b0;
        #1;
        n_tests++; if (bus.skid_empty !== 1'b1) begin n_fail++; $display("FAIL arst_skid_empty: got %0b want 1", bus.skid_empty); end
        n_tests++; if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL arst_dout: got %0h/%0b want 0/0", bus.dout, bus.dout_valid); end
        idle_inputs();
        @(negedge clock);
        resetn = 1'b1;
        tick();
        set_pkt(8'h11, 8'h22, 8'h00, 2, 1'b0);
        model_pkt(8'h05, 8'h36);
        drive_pkt(8'h05, 8'h36);
        n_tests++; if (got_q != exp_q) begin n_fail++; $display("FAIL arst_next_pkt: got %p want %p", got_q, exp_q); end
    endtask

`ifdef ROUTER_ERR_COUNT_EN
    task automatic test_err_count();
        resetn = 1'b0;
        #3;
        n_tests++; if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL errcnt_reset: got %0d want 0", bus.err_count); end
        @(negedge clock);
        resetn = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            set_pkt(8'h11, 8'h22, 8'h00, 2, 1'b0);
            drive_pkt(8'h05, 8'h00);
        end
        n_tests++; if (bus.err_count !== 8'd3) begin n_fail++; $display("FAIL errcnt_three: got %0d want 3", bus.err_count); end
        drive_pkt(8'h05, 8'h36);
        n_tests++; if (bus.err_count !== 8'd3) begin n_fail++; $display("FAIL errcnt_good_keeps: got %0d want 3", bus.err_count); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_invalid_addr();
        test_backpressure();
        test_overflow();
        test_random();
        test_async_reset();
`ifdef ROUTER_ERR_COUNT_EN
        test_err_count();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/router_reg_pkt.md
Name: router_reg_pkt

Overview:
Parametrised datapath register stage of the router, between the input port and the per-destination FIFOs, driven by the router FSM state strobes. It captures the header and forwards header and payload words to the FIFO write bus. An overflow skid buffer of SKID_DEPTH words absorbs payload arriving while the target FIFO is full. It computes running XOR parity over header plus payload and flags a mismatch against the trailing parity word.

Parameters:
DATA_WIDTH, 8, width of data_in/dout and of the parity word
NUM_PORTS, 3, number of valid destinations; address field = data_in[ADDR_BITS-1:0], ADDR_BITS = clog2(NUM_PORTS), minimum 1
SKID_DEPTH, 2, overflow buffer depth in words (>=1)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  reset, asynchronous, active-low
pkt_valid  in  1  high during header/payload; low on parity word
data_in  in  DATA_WIDTH  input word
fifo_full  in  1  selected destination FIFO full
detect_add  in  1  FSM DECODE_ADDRESS strobe
lfd_state  in  1  FSM LOAD_FIRST_DATA strobe
ld_state  in  1  FSM LOAD_DATA strobe
laf_state  in  1  FSM LOAD_AFTER_FULL strobe
full_state  in  1  FSM FIFO_FULL_STATE strobe
rst_int_reg  in  1  clear low_packet_valid
dout  out  DATA_WIDTH  FIFO write data
dout_valid  out  1  dout holds a new word this cycle (FIFO write enable qualifier)
skid_empty  out  1  skid buffer empty (FSM uses to leave LOAD_AFTER_FULL)
skid_ovf  out  1  sticky: word dropped because skid full
parity_done  out  1  parity comparison point reached
low_packet_valid  out  1  parity word received
err  out  1  parity mismatch

Behaviour:
- Reset (resetn low, async): all outputs 0 except skid_empty=1; header, parity registers, skid pointers/count cleared. Reset mid-packet discards skid contents.
- All outputs registered; single clock domain.
- Header: detect_add && pkt_valid && addr<NUM_PORTS -> header<=data_in; internal_parity<=0, packet_parity<=0, parity_done<=0, err<=0, skid_ovf<=0, skid flushed. addr>=NUM_PORTS: header unchanged, no clears.
- lfd_state: dout<=header, dout_valid<=1, internal_parity^=header.
- ld_state && pkt_valid: word accepted; internal_parity^=data_in (independent of full_state).
  - ~fifo_full && skid_empty -> dout<=data_in, dout_valid<=1.
  - otherwise push to skid; skid full -> drop word, skid_ovf<=1 (parity still accumulates).
- ld_state && ~pkt_valid: packet_parity<=data_in, low_packet_valid<=1; word not forwarded, not added to parity.
- laf_state && ~fifo_full && ~skid_empty: pop head to dout, dout_valid<=1; FIFO order preserved. Simultaneous push and pop in the same cycle: count unchanged.
- dout_valid=0 in all other cycles; dout holds its last value.
- parity_done<=1 when low_packet_valid && skid_empty && ~parity_done. Held until the next valid header.
- err<=1 one cycle after parity_done rises if packet_parity!=internal_parity; held until the next valid header.
- low_packet_valid: rst_int_reg has priority and clears it.
- Skid pointers wrap modulo SKID_DEPTH; count width clog2(SKID_DEPTH+1).

Optional Feature:
ROUTER_ERR_COUNT_EN: when defined, adds output err_count [7:0]. It increments once per err rising edge and saturates at 255. It is cleared only by reset. When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Good packet, NUM_PORTS=3: header 8'h05 (addr 1), payload 8'h11, 8'h22, parity 8'h36 -> dout sequence 05, 11, 22 with dout_valid; parity_done=1; err stays 0.
- Bad parity: same packet with parity 8'h00 -> parity_done=1, err=1 the next cycle; err clears on the next valid header.
- Backpressure, SKID_DEPTH=2: fifo_full=1 during payload 8'hA1, 8'hA2; release in laf_state -> dout A1 then A2, skid_empty returns to 1, skid_ovf=0.
- Overflow: fifo_full=1 during 3 payload words 8'h01, 8'h02, 8'h03 -> skid_ovf=1; drain yields 01, 02 only; parity still covers all 3 words.
- Invalid address: detect_add with data_in=8'h03 -> header unchanged, no flags cleared. Async resetn pulse mid-payload -> outputs 0, skid_empty=1 immediately.
- ROUTER_ERR_COUNT_EN defined: 3 bad-parity packets -> err_count=3; a good packet leaves it at 3.
